uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one `uart_core` transmitter between `NREQ` independent requesters. Each requester presents a byte and its own 5-bit frame control word. The arbiter grants one requester at a time and drives the core's `tx_start`/`tx_data`/`ctrl_word` inputs. It tracks the core's `tx_busy` through a full frame, then returns a completion or error pulse to the granted requester. It sits between the requester logic and `uart_core` inside the UART subsystem.

---
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_core transmitter among NREQ requesters
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [5*NREQ-1:0] req_ctrl,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [4:0]        ctrl_word,
    input  logic              tx_busy,
    output logic              arb_busy
);
    localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t          state;
    logic [LW-1:0]   last, win;
    logic            found;
    logic [7:0]      cnt;
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && |(req & (NREQ'(1) << ((int'(last) + k) % NREQ)))) begin
                found = 1'b1;
                win   = LW'((int'(last) + k) % NREQ);
            end
        end
    end
    // grant doubles as the owner mask for the done/err pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            err       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            ctrl_word <= 5'h00;
            arb_busy  <= 1'b0;
            last      <= LW'(NREQ - 1);
            cnt       <= 8'd0;
        end else begin
            done     <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            case (state)
                IDLE: if (enable && found) begin
                    state     <= ISSUE;
                    grant     <= NREQ'(1) << win;
                    tx_data   <= 8'(req_data >> (8 * win));
                    ctrl_word <= 5'(req_ctrl >> (5 * win));
                    last      <= win;
                    tx_start  <= 1'b1;
                    arb_busy  <= 1'b1;
                end
                ISSUE: begin
                    cnt   <= 8'd0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (cnt == 8'(BUSY_TIMEOUT - 2)) begin
                    err      <= grant;
                    grant    <= '0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    done     <= grant;
                    grant    <= '0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
